// File: rtl/ro_entropy_collector.sv
// ---------------------------------------------------------------------------
// ro_entropy_collector: samples a synchronised ring-oscillator bit, optionally
// von Neumann debiases it and packs it MSB-first into words.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ro_entropy_collector #(
  parameter int SYNC_STAGES = 2,
  parameter int WIDTH       = 32,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 enable,
  input  logic                 debias_en,
  input  logic [DIV_WIDTH-1:0] sample_div,
  input  logic                 ro_in,
  input  logic                 ack,
  output logic [WIDTH-1:0]     data,
  output logic                 valid,
  output logic [15:0]          drop_count
);

  localparam int                CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(WIDTH - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   ro_s;
  logic [DIV_WIDTH-1:0]   timer;
  logic                   phase;
  logic                   first_bit;
  logic                   debias_q;
  logic [WIDTH-1:0]       shreg;
  logic [CNT_W-1:0]       bit_count;
  logic                   pending;

  logic                   tick;
  logic                   debias_chg;
  logic                   eff_phase;
  logic                   emit;
  logic                   emit_bit;
  logic [WIDTH-1:0]       next_word;
  logic                   word_done;
  logic                   ack_take;
  logic                   drop_inc;

  // Synchroniser runs unconditionally so ro_s is settled when enable rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ro_in};
    end
  end

  assign ro_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    tick       = enable && (timer == sample_div);
    debias_chg = (debias_en != debias_q);
    // A debias mode change restarts pairing, even on a tick in the same cycle.
    eff_phase  = phase && !debias_chg;
    emit       = 1'b0;
    emit_bit   = ro_s;
    if (tick) begin
      if (debias_en) begin
        if (eff_phase) begin
          emit     = (ro_s != first_bit);
          emit_bit = first_bit;
        end
      end else begin
        emit = 1'b1;
      end
    end
    next_word = {shreg[WIDTH-2:0], emit_bit};
    word_done = emit && !pending && (bit_count == LAST_BIT);
    ack_take  = valid && ack;
    drop_inc  = emit && pending;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer     <= '0;
      phase     <= 1'b0;
      first_bit <= 1'b0;
      debias_q  <= 1'b0;
    end else begin
      debias_q <= debias_en;
      if (!enable || tick) begin
        timer <= '0;
      end else begin
        timer <= timer + 1'b1;
      end

      if (!enable) begin
        phase <= 1'b0;
      end else if (tick && debias_en) begin
        phase <= !eff_phase;
        if (!eff_phase) begin
          first_bit <= ro_s;
        end
      end else if (debias_chg) begin
        phase <= 1'b0;
      end
    end
  end

  // Later assignments win: a completing word overrides the ack-driven valid clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg      <= '0;
      bit_count  <= '0;
      pending    <= 1'b0;
      data       <= '0;
      valid      <= 1'b0;
      drop_count <= '0;
    end else begin
      if (drop_inc && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end

      if (ack_take) begin
        if (pending) begin
          data      <= shreg;
          pending   <= 1'b0;
          bit_count <= '0;
        end else begin
          valid <= 1'b0;
        end
      end

      if (!enable) begin
        bit_count <= '0;
      end else if (emit && !pending) begin
        shreg <= next_word;
        if (word_done) begin
          bit_count <= '0;
          if (!valid || ack) begin
            data  <= next_word;
            valid <= 1'b1;
          end else begin
            pending <= 1'b1;
          end
        end else begin
          bit_count <= bit_count + 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ro_entropy_collector.sv
// ---------------------------------------------------------------------------
// tb_ro_entropy_collector: directed self-checking bench for the collector.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ro_entropy_collector;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        debias_en;
  logic [15:0] sample_div;
  logic        ro_in;
  logic        ack;
  logic [31:0] data;
  logic        valid;
  logic [15:0] drop_count;

  int n_tests = 0;
  int n_fail  = 0;

  ro_entropy_collector #(
    .SYNC_STAGES(2),
    .WIDTH      (32),
    .DIV_WIDTH  (16)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .enable    (enable),
    .debias_en (debias_en),
    .sample_div(sample_div),
    .ro_in     (ro_in),
    .ack       (ack),
    .data      (data),
    .valid     (valid),
    .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    enable  = 1'b0;
    ack     = 1'b0;
    step(2);
    reset_n = 1'b1;
    step(5);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n    = 1'b0;
    enable     = 1'b0;
    debias_en  = 1'b0;
    sample_div = 16'd0;
    ro_in      = 1'b1;
    ack        = 1'b0;

    // Raw all-ones word, overrun while stalled, ack hand-over
    step(2);
    check("rst_data",  data, 32'h0);
    check("rst_valid", {31'h0, valid}, 32'h0);
    check("rst_drop",  {16'h0, drop_count}, 32'h0);
    reset_n = 1'b1;
    step(5);
    enable = 1'b1;
    step(31);
    check("a_valid_e31", {31'h0, valid}, 32'h0);
    step(1);
    check("a_valid_e32", {31'h0, valid}, 32'h1);
    check("a_data_e32",  data, 32'hFFFF_FFFF);
    ro_in = 1'b0;
    step(32);
    check("a_valid_e64", {31'h0, valid}, 32'h1);
    check("a_data_e64",  data, 32'hFFFF_FFFF);
    check("a_drop_e64",  {16'h0, drop_count}, 32'd0);
    step(3);
    check("a_drop_e67",  {16'h0, drop_count}, 32'd3);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("a_data_e68",  data, 32'hC000_0000);
    check("a_valid_e68", {31'h0, valid}, 32'h1);
    check("a_drop_e68",  {16'h0, drop_count}, 32'd4);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("a_valid_e70", {31'h0, valid}, 32'h0);
    check("a_drop_e70",  {16'h0, drop_count}, 32'd4);
    step(20);
    ro_in = 1'b1;
    step(10);
    check("a_valid_e100", {31'h0, valid}, 32'h1);
    check("a_data_e100",  data, 32'h0000_00FF);
    check("a_drop_e100",  {16'h0, drop_count}, 32'd4);
    step(5);
    #1 reset_n = 1'b0;
    #1;
    check("async_rst_data",  data, 32'h0);
    check("async_rst_valid", {31'h0, valid}, 32'h0);
    check("async_rst_drop",  {16'h0, drop_count}, 32'h0);

    // Completion coinciding with ack, then enable drop mid-word
    ro_in = 1'b1;
    do_reset();
    enable = 1'b1;
    step(32);
    ro_in = 1'b0;
    step(31);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("b_data_e64",  data, 32'hC000_0000);
    check("b_valid_e64", {31'h0, valid}, 32'h1);
    check("b_drop_e64",  {16'h0, drop_count}, 32'd0);
    step(1);
    ack = 1'b1;
    step(1);
    ack = 1'b0;
    check("b_valid_e66", {31'h0, valid}, 32'h0);
    step(4);
    ro_in = 1'b1;
    step(1);
    enable = 1'b0;
    step(4);
    enable = 1'b1;
    step(31);
    check("b_valid_e106", {31'h0, valid}, 32'h0);
    step(1);
    check("b_valid_e107", {31'h0, valid}, 32'h1);
    check("b_data_e107",  data, 32'hFFFF_FFFF);

    // Debias: constant input never emits; 1,0 pairs emit ones
    ro_in     = 1'b0;
    debias_en = 1'b1;
    do_reset();
    enable = 1'b1;
    step(1000);
    check("c_valid_const", {31'h0, valid}, 32'h0);
    check("c_drop_const",  {16'h0, drop_count}, 32'd0);
    enable = 1'b0;
    step(1);
    for (int m = -3; m < 64; m++) begin
      ro_in = logic'((m + 3) & 1);
      if (m == 0) enable = 1'b1;
      step(1);
      if (m == 62) check("c_valid_g63", {31'h0, valid}, 32'h0);
    end
    check("c_valid_g64", {31'h0, valid}, 32'h1);
    check("c_data_g64",  data, 32'hFFFF_FFFF);
    check("c_drop_g64",  {16'h0, drop_count}, 32'd0);

    // Divided sample rate: tick every 4 cycles, alternating bits
    debias_en  = 1'b0;
    sample_div = 16'd3;
    ro_in      = 1'b0;
    do_reset();
    for (int m = -3; m < 128; m++) begin
      ro_in = logic'(((m + 3) >> 2) & 1);
      if (m == 0) enable = 1'b1;
      step(1);
      if (m == 126) check("d_valid_h127", {31'h0, valid}, 32'h0);
    end
    check("d_valid_h128", {31'h0, valid}, 32'h1);
    check("d_data_h128",  data, 32'hAAAA_AAAA);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
